// File: rtl/spi_master_multi.sv
// SPI master for NUM_CS slaves: runtime mode, clock divider and bit order.
// Multi-word bursts under one chip select; every SPI pin is driven from a flop.
module spi_master_multi #(
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned WAIT_W = 8,
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_lsb_first,
  input  logic [WAIT_W-1:0] wait_duration,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned     HP_W     = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] HP_LAST  = HP_W'(2 * DATA_W - 1);
  localparam logic [CS_W:0]   NUM_CS_L = (CS_W + 1)'(NUM_CS);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StSetup = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  logic [2:0]        state;
  logic [CS_W-1:0]   sel_q;
  logic              cpol_q, cpha_q, lsb_q, last_q, first_q;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [WAIT_W-1:0] wait_q, wait_cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic [DATA_W-1:0] tx_sh, tx_nxt, rx_sh, rx_nxt;
  logic [NUM_CS-1:0] cs_dec;
  logic              cs_ok, hp_end, leading, final_edge, do_sample, do_shift;

  assign tx_ready = (state == StLoad);
  assign busy     = (state != StIdle);

  always_comb begin
    cs_ok      = {1'b0, cs_sel} < NUM_CS_L;
    hp_end     = (state == StShift) && (div_cnt == '0);
    leading    = ~hp_cnt[0];
    final_edge = hp_end && (hp_cnt == HP_LAST);
    // Even half-periods end on a leading edge; CPHA picks which edge samples.
    do_sample  = hp_end && (leading ^ cpha_q);
    // With CPHA=1 the first bit is already on mosi before the first leading edge.
    do_shift   = hp_end && (leading == cpha_q) && !final_edge && !(cpha_q && (hp_cnt == '0));
    tx_nxt     = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
    rx_nxt     = rx_sh;
    if (do_sample) begin
      rx_nxt = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    end
    cs_dec = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (sel_q == CS_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      sel_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      first_q  <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      wait_q   <= '0;
      wait_cnt <= '0;
      hp_cnt   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      rx_sh    <= rx_nxt;
      case (state)
        StIdle: begin
          if (start && cs_ok) begin
            sel_q   <= cs_sel;
            cpol_q  <= cfg_mode[1];
            cpha_q  <= cfg_mode[0];
            lsb_q   <= cfg_lsb_first;
            div_q   <= cfg_div;
            wait_q  <= wait_duration;
            sclk    <= cfg_mode[1];
            first_q <= 1'b1;
            state   <= StLoad;
          end
        end
        StLoad: begin
          if (tx_valid) begin
            tx_sh   <= tx_data;
            mosi    <= lsb_q ? tx_data[0] : tx_data[DATA_W-1];
            last_q  <= tx_last;
            first_q <= 1'b0;
            div_cnt <= div_q;
            hp_cnt  <= '0;
            if (first_q) begin
              cs_n <= ~cs_dec;
            end
            if (first_q && (wait_q != '0)) begin
              wait_cnt <= wait_q - 1'b1;
              state    <= StSetup;
            end else begin
              state <= StShift;
            end
          end
        end
        StSetup: begin
          if (wait_cnt == '0) begin
            state <= StShift;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        StShift: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= div_q;
            sclk    <= ~sclk;
            hp_cnt  <= hp_cnt + 1'b1;
            if (do_shift) begin
              tx_sh <= tx_nxt;
              mosi  <= lsb_q ? tx_sh[1] : tx_sh[DATA_W-2];
            end
            if (final_edge) begin
              rx_data  <= rx_nxt;
              rx_valid <= 1'b1;
              if (!last_q) begin
                state <= StLoad;
              end else if (wait_q != '0) begin
                wait_cnt <= wait_q - 1'b1;
                state    <= StHold;
              end else begin
                cs_n  <= '1;
                done  <= 1'b1;
                state <= StIdle;
              end
            end
          end
        end
        StHold: begin
          if (wait_cnt == '0) begin
            cs_n  <= '1;
            done  <= 1'b1;
            state <= StIdle;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
